// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC types, opcode constants and defaults
package sisc_pkg;

    localparam int ADDR_W_DEF = 16;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 28;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'h0;
    localparam opcode_t OP_ADD  = 4'h1;
    localparam opcode_t OP_SUB  = 4'h2;
    localparam opcode_t OP_LD   = 4'h3;
    localparam opcode_t OP_ST   = 4'h4;
    localparam opcode_t OP_BR   = 4'h5;
    localparam opcode_t OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DELIVER = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_t;

    function automatic opcode_t get_opcode(input logic [31:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/sisc_ifetch_if.sv
// rtl/sisc_ifetch_if.sv - instruction memory req/ack bus
interface sisc_ifetch_if
    import sisc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/sisc_pc.sv
// rtl/sisc_pc.sv - program counter with reset load, wrap increment, redirect load
module sisc_pc
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    // Redirect wins over increment; increment wraps naturally at ADDR_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/sisc_ifetch.sv
// rtl/sisc_ifetch.sv - SISC instruction fetch FSM with memory req/ack and core valid/stall
module sisc_ifetch
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter opcode_t           HALT_OP  = OP_HALT
) (
    input  logic                 clk,
    input  logic                 rst,
    sisc_ifetch_if.master        mem,
    output logic [31:0]          instruction,
    output logic                 instr_valid,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [ADDR_W-1:0]    br_addr,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted
);

    fetch_state_t state;
    fetch_state_t state_next;

    // Set for one cycle after a redirect abandons an outstanding request.
    logic drop_q;

    logic req;
    logic is_halt;
    logic pc_inc;
    logic pc_load;

    assign is_halt = (get_opcode(instruction) == HALT_OP);

    sisc_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_addr (br_addr),
        .pc        (pc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Instruction capture and abandoned-request marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instruction <= '0;
            drop_q      <= 1'b0;
        end else begin
            if (req && mem.mem_ack && !br_taken) begin
                instruction <= mem.mem_rdata;
            end
            drop_q <= req && br_taken;
        end
    end

    // Next-state logic: redirect beats both ack and accept.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: begin
                if (br_taken) begin
                    state_next = ST_FETCH;
                end else if (req && mem.mem_ack) begin
                    state_next = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (br_taken) begin
                    state_next = ST_FETCH;
                end else if (!stall) begin
                    state_next = is_halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Outputs and PC controls decoded from the current state.
    always_comb begin
        req         = (state == ST_FETCH) && !drop_q;
        instr_valid = (state == ST_DELIVER);
        halted      = (state == ST_HALTED);
        pc_load     = br_taken && (state != ST_HALTED);
        pc_inc      = (state == ST_DELIVER) && !stall && !br_taken && !is_halt;
    end

    assign mem.mem_req  = req;
    assign mem.mem_addr = pc;

endmodule

// File: tb/tb_sisc_ifetch.sv
// tb/tb_sisc_ifetch.sv - directed self-checking bench for sisc_ifetch
module tb_sisc_ifetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_addr;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [15:0] pc;
    logic        halted;

    int n_checks;
    int n_fail;

    sisc_ifetch_if #(.ADDR_W(16)) mem_bus ();

    sisc_ifetch #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (mem_bus),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .pc          (pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        stall             = 1'b0;
        br_taken          = 1'b0;
        br_addr           = 16'h0000;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_req", mem_bus.mem_req, 1'b1);
        chk("rst_addr", mem_bus.mem_addr, 16'h0000);
        rst = 1'b0;

        // First fetch, ack two cycles into the request
        @(negedge clk);
        chk("f1_req", mem_bus.mem_req, 1'b1);
        chk("f1_addr", mem_bus.mem_addr, 16'h0000);
        @(negedge clk);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h10000012;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("f1_instr", instruction, 32'h10000012);
        chk("f1_valid", instr_valid, 1'b1);
        chk("f1_req_low", mem_bus.mem_req, 1'b0);
        chk("f1_pc", pc, 16'h0000);
        @(negedge clk);
        chk("f1_valid_drop", instr_valid, 1'b0);
        chk("f2_req", mem_bus.mem_req, 1'b1);
        chk("f2_addr", mem_bus.mem_addr, 16'h0001);

        // Stall for four cycles in DELIVER
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h20000034;
        stall             = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_bus.mem_ack = 1'b0;
            chk("st_valid", instr_valid, 1'b1);
            chk("st_instr", instruction, 32'h20000034);
            chk("st_req", mem_bus.mem_req, 1'b0);
            if (i == 3) stall = 1'b0;
        end
        @(negedge clk);
        chk("st_after_req", mem_bus.mem_req, 1'b1);
        chk("st_after_addr", mem_bus.mem_addr, 16'h0002);

        // Redirect in the same cycle as ack
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h30000000;
        br_taken          = 1'b1;
        br_addr           = 16'h0040;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        br_taken        = 1'b0;
        chk("br_valid", instr_valid, 1'b0);
        chk("br_req_gap", mem_bus.mem_req, 1'b0);
        chk("br_pc", pc, 16'h0040);
        chk("br_instr_kept", instruction, 32'h20000034);
        @(negedge clk);
        chk("br_req", mem_bus.mem_req, 1'b1);
        chk("br_addr", mem_bus.mem_addr, 16'h0040);

        // Redirect to the top address, then wrap on accept
        br_taken = 1'b1;
        br_addr  = 16'hFFFF;
        @(negedge clk);
        br_taken = 1'b0;
        chk("wr_pc", pc, 16'hFFFF);
        chk("wr_req_gap", mem_bus.mem_req, 1'b0);
        @(negedge clk);
        chk("wr_req", mem_bus.mem_req, 1'b1);
        chk("wr_addr", mem_bus.mem_addr, 16'hFFFF);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h40000000;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("wr_valid", instr_valid, 1'b1);
        @(negedge clk);
        chk("wr_next_req", mem_bus.mem_req, 1'b1);
        chk("wr_next_addr", mem_bus.mem_addr, 16'h0000);
        chk("wr_next_pc", pc, 16'h0000);

        // HALT word accepted together with a redirect: redirect wins
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hF0000000;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("bh_valid", instr_valid, 1'b1);
        br_taken = 1'b1;
        br_addr  = 16'h0010;
        @(negedge clk);
        br_taken = 1'b0;
        chk("bh_halted", halted, 1'b0);
        chk("bh_valid_drop", instr_valid, 1'b0);
        chk("bh_req", mem_bus.mem_req, 1'b1);
        chk("bh_addr", mem_bus.mem_addr, 16'h0010);

        // HALT accepted
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hF0000000;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        chk("h_valid", instr_valid, 1'b1);
        @(negedge clk);
        chk("h_halted", halted, 1'b1);
        chk("h_req", mem_bus.mem_req, 1'b0);
        chk("h_valid_drop", instr_valid, 1'b0);
        chk("h_pc", pc, 16'h0010);
        br_taken = 1'b1;
        br_addr  = 16'h0020;
        @(negedge clk);
        br_taken = 1'b0;
        chk("h_br_halted", halted, 1'b1);
        chk("h_br_pc", pc, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("h_req_hold", mem_bus.mem_req, 1'b0);
        end

        // Reset leaves HALTED asynchronously
        rst = 1'b1;
        #1;
        chk("hr_halted", halted, 1'b0);
        chk("hr_pc", pc, 16'h0000);
        chk("hr_instr", instruction, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("hr_req", mem_bus.mem_req, 1'b1);
        chk("hr_addr", mem_bus.mem_addr, 16'h0000);

        // Reset mid-handshake, late ack ignored
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h60000000;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("mr_req", mem_bus.mem_req, 1'b1);
        chk("mr_addr", mem_bus.mem_addr, 16'h0001);
        chk("mr_instr", instruction, 32'h60000000);
        rst = 1'b1;
        #1;
        chk("mr_rst_instr", instruction, 32'h0);
        chk("mr_rst_pc", pc, 16'h0000);
        chk("mr_rst_valid", instr_valid, 1'b0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        rst             = 1'b0;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("mr_late_valid", instr_valid, 1'b0);
        chk("mr_late_instr", instruction, 32'h0);
        chk("mr_restart_req", mem_bus.mem_req, 1'b1);
        chk("mr_restart_addr", mem_bus.mem_addr, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
